serial_periph_ctrl: RTL and testbench
=====================================

// Module: serial_periph_ctrl
// PURPOSE
//  Parametrised serial master for the analog front-end chips (ADC, DAC, VGA gain pair) on clk48.
//  Replaces the per-chip fixed passthrough/test-toggle wiring with one generic word shifter.
//  Supports NUM_CS chip selects, programmable word width and SCLK rate, with mode-0 full-duplex capture.
//  The top level instantiates one per peripheral group.
// PARAMETERS
//  NUM_CS   2   number of chip-select outputs (>=1)
//  WORD_W   16  bits per transaction, MSB first (2..32)
//  CLK_DIV  4   clk48 cycles per SCLK half-period (>=1)
//  CS_SETUP 2   cycles from cs_n fall to first SCLK rise-half start (>=1)
//  CS_HOLD  2   cycles from last SCLK fall to cs_n rise (>=1)
//  CS_GAP   1   minimum cycles cs_n held high before next transaction (>=1)
// PORTS
//  clk48     in   1                 system clock; all logic on posedge
//  reset_n   in   1                 synchronous, active-low reset
//  start     in   1                 request transaction; sampled only when busy=0
//  cs_sel    in   $clog2(NUM_CS)    target chip index, latched with start (width min 1)
//  tx_word   in   WORD_W            word to shift out, latched with start
//  busy      out  1                 transaction in progress (incl. gap)
//  done      out  1                 one-cycle pulse, transaction complete
//  err       out  1                 one-cycle pulse, start with cs_sel>=NUM_CS
//  rx_word   out  WORD_W            captured word, valid from done until next done
//  cs_n      out  NUM_CS            active-low chip selects, at most one low
//  sclk      out  1                 serial clock, idle low (CPOL=0)
//  mosi      out  1                 serial data out
//  miso      in   1                 serial data in
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): cs_n=all 1, sclk=0, mosi=0, busy=0, done=0, err=0, rx_word=0,
//    state IDLE. Mid-transaction reset aborts immediately; no done pulse.
//  - States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  - IDLE: start=1 and cs_sel<NUM_CS at edge T -> at T+1: busy=1, cs_n[cs_sel]=0,
//    mosi=tx_word[WORD_W-1], SETUP. start with cs_sel>=NUM_CS -> err=1 at T+1, stay IDLE.
//  - SETUP: CS_SETUP cycles, sclk=0, then SHIFT.
//  - SHIFT: per bit, sclk low CLK_DIV cycles then high CLK_DIV cycles (mode 0).
//    Edge where sclk goes 0->1: sample miso into shift reg LSB. Edge where sclk goes 1->0:
//    mosi advances to next bit. After bit 0 high half, sclk=0, mosi holds, enter HOLD.
//  - HOLD: CS_HOLD cycles, then cs_n all 1, done=1, rx_word updated (same edge), enter GAP.
//  - GAP: CS_GAP cycles incl. done cycle, busy stays 1; then IDLE with busy=0.
//  - busy high for exactly CS_SETUP + 2*CLK_DIV*WORD_W + CS_HOLD + CS_GAP cycles.
//  - start while busy=1 is ignored (no queueing); start on the cycle busy falls is accepted.
//  - Bit and divider counters wrap-free: counters sized $clog2(WORD_W), $clog2(CLK_DIV)+1.
//  - rx_word width = WORD_W; miso sampled raw (external sync not required at these rates).
// CONFIGURATION
//  - SERIAL_RX_EN defined: miso shifted in, rx_word driven as above.
//  - Not defined: miso unused, rx_word constant 0, capture register removed (DAC/VGA-only builds).
//    Timing, done and busy identical in both builds.
// STRUCTURE
//  - Shared include serial_defs.vh: state localparams (ST_IDLE..ST_GAP), mode constants.
//  - Sub-module serial_bit_timer: CLK_DIV half-period tick generator with sync clear;
//    outputs rise_tick/fall_tick one cycle wide. FSM and shift regs stay in top.
// TESTING (defaults, SERIAL_RX_EN defined unless noted)
//  1 start, cs_sel=1, tx=16'hA55A, miso loops mosi -> cs_n=2'b01 for 132 cycles, 16 sclk rises,
//    mosi sequence A55A MSB first, done once, rx_word=16'hA55A, busy high 133 cycles.
//  2 miso tied 1, tx=0, cs_sel=0 -> rx_word=16'hFFFF, mosi 0 throughout, cs_n=2'b10 while active.
//  3 start pulsed every cycle during transaction -> exactly one transaction; next begins the
//    cycle after busy falls; cs_n high >= CS_GAP cycles between.
//  4 NUM_CS=3, cs_sel=3 -> err pulse 1 cycle, busy stays 0, cs_n=3'b111, no sclk activity.
//  5 reset_n=0 at cycle 40 of transaction -> next edge cs_n all 1, sclk 0, busy 0, no done;
//    new start after release completes normally.
//  6 SERIAL_RX_EN undefined, WORD_W=8, CLK_DIV=1 -> rx_word=0, busy high 2+16+2+1=21 cycles.

Source files
------------

// File: rtl/serial_periph_ctrl_pkg.sv
// Shared types and helpers for the serial peripheral controller.
// Optional receive path is controlled by the SERIAL_RX_EN macro (see serial_periph_ctrl.sv).
package serial_periph_ctrl_pkg;

  // Transaction sequencer states, in the order a transaction walks through them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Serial mode is fixed to mode 0: SCLK idles low, data captured on the rising edge.
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  // Largest of three cycle counts; sizes the shared setup/hold/gap counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_periph_ctrl_if.sv
// Request/response bus between a host and serial_periph_ctrl.
// Handshake: the host raises start together with cs_sel/tx_word; the request is taken
// on a clock edge only when busy=0 (no ready signal, a start seen while busy=1 is
// dropped). Completion is the one-cycle done pulse, after which rx_word holds the
// captured word until the next done; err pulses for one cycle on a bad cs_sel.
interface serial_periph_ctrl_if #(
  parameter int NUM_CS = 2,
  parameter int WORD_W = 16
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic [CS_W-1:0]   cs_sel;
  logic [WORD_W-1:0] tx_word;
  logic              busy;
  logic              done;
  logic              err;
  logic [WORD_W-1:0] rx_word;

  modport master (output start, cs_sel, tx_word, input busy, done, err, rx_word);
  modport slave  (input start, cs_sel, tx_word, output busy, done, err, rx_word);
endinterface

// File: rtl/serial_periph_ctrl_bit_timer.sv
// SCLK half-period tick generator: counts CLK_DIV cycles per half while run=1,
// and is held cleared (low half, count 0) whenever run=0.
module serial_periph_ctrl_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk48,
  input  logic reset_n,
  input  logic run,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          high_half;
  logic          half_end;

  // A tick marks the last cycle of a half; rise ends a low half, fall ends a high half.
  assign half_end  = run && (div_cnt == DIV_LAST);
  assign rise_tick = half_end && !high_half;
  assign fall_tick = half_end && high_half;

  // Divider counter and half-period phase, cleared synchronously when not running.
  always_ff @(posedge clk48) begin
    if (!reset_n || !run) begin
      div_cnt   <= '0;
      high_half <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      high_half <= ~high_half;
    end else begin
      div_cnt   <= div_cnt + DW'(1);
    end
  end
endmodule

// File: rtl/serial_periph_ctrl.sv
// Generic mode-0 serial master: one word per transaction, MSB first, with selectable
// chip select and programmable setup/hold/gap timing.
// Build option: define SERIAL_RX_EN to capture miso into rx_word; otherwise rx_word is 0.
module serial_periph_ctrl
  import serial_periph_ctrl_pkg::*;
#(
  parameter int NUM_CS   = 2,
  parameter int WORD_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 1
) (
  input  logic                clk48,
  input  logic                reset_n,
  serial_periph_ctrl_if.slave bus,
  output logic [NUM_CS-1:0]   cs_n,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output state_t              state_dbg
);
  localparam int BW = $clog2(WORD_W);
  localparam int CW = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     cyc_cnt;
  logic [WORD_W-1:0] tx_sh;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              rise_tick;
  logic              fall_tick;
  logic              sel_ok;
  logic              hold_end;

  assign sel_ok    = int'(bus.cs_sel) < NUM_CS;
  assign hold_end  = (state == ST_HOLD) && (cyc_cnt == '0);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign state_dbg = state;

  serial_periph_ctrl_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk48     (clk48),
    .reset_n   (reset_n),
    .run       (state == ST_SHIFT),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Transaction sequencer: chip select, SCLK and MOSI are all registered here.
  always_ff @(posedge clk48) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cs_n    <= '1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      tx_sh   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (sel_ok) begin
              state   <= ST_SETUP;
              busy_q  <= 1'b1;
              cs_n    <= ~(NUM_CS'(1) << bus.cs_sel);
              mosi    <= bus.tx_word[WORD_W-1];
              tx_sh   <= bus.tx_word;
              bit_cnt <= BW'(WORD_W - 1);
              cyc_cnt <= CW'(CS_SETUP - 1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (cyc_cnt == '0) state <= ST_SHIFT;
          else cyc_cnt <= cyc_cnt - CW'(1);
        end
        ST_SHIFT: begin
          if (rise_tick) begin
            sclk <= 1'b1;
          end else if (fall_tick) begin
            sclk <= 1'b0;
            if (bit_cnt == '0) begin
              // Last bit done: mosi keeps bit 0, chip select stays low for the hold time.
              state   <= ST_HOLD;
              cyc_cnt <= CW'(CS_HOLD - 1);
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
              tx_sh   <= {tx_sh[WORD_W-2:0], 1'b0};
              mosi    <= tx_sh[WORD_W-2];
            end
          end
        end
        ST_HOLD: begin
          if (cyc_cnt == '0) begin
            state   <= ST_GAP;
            cs_n    <= '1;
            done_q  <= 1'b1;
            cyc_cnt <= CW'(CS_GAP - 1);
          end else begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end
        end
        ST_GAP: begin
          if (cyc_cnt == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_RX_EN
  logic [WORD_W-1:0] rx_sh;
  logic [WORD_W-1:0] rx_q;

  // Capture miso on each SCLK rising edge; publish the word on the done edge.
  always_ff @(posedge clk48) begin
    if (!reset_n) begin
      rx_sh <= '0;
      rx_q  <= '0;
    end else begin
      if (rise_tick) rx_sh <= {rx_sh[WORD_W-2:0], miso};
      if (hold_end)  rx_q  <= rx_sh;
    end
  end

  assign bus.rx_word = rx_q;
`else
  logic unused_rx_inputs;
  assign unused_rx_inputs = miso ^ hold_end;
  assign bus.rx_word      = '0;
`endif

endmodule

// File: tb/tb_serial_periph_ctrl.sv
// Bench for serial_periph_ctrl: two instances (default 2-CS/16-bit/div4 and a
// 3-CS/8-bit/div1 build), table vectors, corner sequences and random transactions.
module tb_serial_periph_ctrl;
  import serial_periph_ctrl_pkg::*;

  localparam int S = 2, H = 2, G = 1;
  localparam int A_W = 16, A_D = 4, B_W = 8, B_D = 1;

  // clock / reset
  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;
  logic reset_n;

  serial_periph_ctrl_if #(.NUM_CS(2), .WORD_W(16)) bus_a ();
  serial_periph_ctrl_if #(.NUM_CS(3), .WORD_W(8))  bus_b ();

  logic [1:0] cs_n_a;
  logic [2:0] cs_n_b;
  logic       sclk_a, sclk_b, mosi_a, mosi_b, miso_a, miso_b;
  state_t     st_a, st_b;
  logic       miso_loop;
  logic       miso_drv;

  assign miso_a = miso_loop ? mosi_a : miso_drv;
  assign miso_b = miso_loop ? mosi_b : miso_drv;

  serial_periph_ctrl #(.NUM_CS(2), .WORD_W(16), .CLK_DIV(4), .CS_SETUP(S), .CS_HOLD(H), .CS_GAP(G)) u_dut_a (
    .clk48(clk48), .reset_n(reset_n), .bus(bus_a), .cs_n(cs_n_a), .sclk(sclk_a),
    .mosi(mosi_a), .miso(miso_a), .state_dbg(st_a));

  serial_periph_ctrl #(.NUM_CS(3), .WORD_W(8), .CLK_DIV(1), .CS_SETUP(S), .CS_HOLD(H), .CS_GAP(G)) u_dut_b (
    .clk48(clk48), .reset_n(reset_n), .bus(bus_b), .cs_n(cs_n_b), .sclk(sclk_b),
    .mosi(mosi_b), .miso(miso_b), .state_dbg(st_b));

  // monitor view of the currently selected instance
  int          sel_dut;
  logic        m_busy, m_done, m_err, m_sclk, m_mosi;
  logic [2:0]  m_cs_n;
  logic [31:0] m_rx;
  state_t      m_st;

  always_comb begin
    if (sel_dut == 0) begin
      m_busy = bus_a.busy; m_done = bus_a.done; m_err = bus_a.err;
      m_sclk = sclk_a; m_mosi = mosi_a; m_cs_n = {1'b1, cs_n_a};
      m_rx = 32'(bus_a.rx_word); m_st = st_a;
    end else begin
      m_busy = bus_b.busy; m_done = bus_b.done; m_err = bus_b.err;
      m_sclk = sclk_b; m_mosi = mosi_b; m_cs_n = cs_n_b;
      m_rx = 32'(bus_b.rx_word); m_st = st_b;
    end
  end

  // scoreboard counters
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: transaction figures derived from the timing rules
  function automatic int dw(input int d);
    return (d == 0) ? A_W : B_W;
  endfunction
  function automatic int dd(input int d);
    return (d == 0) ? A_D : B_D;
  endfunction
  function automatic int model_busy(input int d);
    return S + 2 * dd(d) * dw(d) + H + G;
  endfunction
  function automatic logic [31:0] mask_w(input int d);
    return (dw(d) == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw(d)) - 32'd1);
  endfunction
  function automatic logic [31:0] model_rx(input int d, input bit loop, input logic [31:0] tx,
                                           input logic [31:0] mw);
`ifdef SERIAL_RX_EN
    return (loop ? tx : mw) & mask_w(d);
`else
    return 32'd0 & {d, loop, tx[0], mw[0]};
`endif
  endfunction

  // driver
  task automatic drive(input int d, input logic st, input int sel, input logic [31:0] tx);
    if (d == 0) begin
      bus_a.start = st; bus_a.cs_sel = sel[0]; bus_a.tx_word = tx[15:0];
    end else begin
      bus_b.start = st; bus_b.cs_sel = sel[1:0]; bus_b.tx_word = tx[7:0];
    end
  endtask

  task automatic check_idle(input int d, input string tag, input bit chk_data);
    sel_dut = d;
    #1;
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_done"}, 32'(m_done), 32'd0);
    chk({tag, "_err"},  32'(m_err),  32'd0);
    chk({tag, "_cs_n"}, 32'(m_cs_n), 32'h7);
    chk({tag, "_sclk"}, 32'(m_sclk), 32'd0);
    chk({tag, "_state"}, 32'(m_st), 32'(ST_IDLE));
    if (chk_data) begin
      chk({tag, "_mosi"}, 32'(m_mosi), 32'd0);
      chk({tag, "_rx"},   m_rx,        32'd0);
    end
  endtask

  // One full transaction, observed cycle by cycle on the falling edge.
  task automatic run_txn(input string nm, input int d, input int sel, input logic [31:0] tx,
                         input bit loop, input logic [31:0] mw, input bit hammer,
                         input logic [2:0] exp_cs, input int exp_busy, input logic [31:0] exp_rx);
    int busy_len, cs_low, rises, dones, errs, first_rise, done_at, bad_cs, w, dv, c;
    logic [31:0] mosi_w;
    logic prev_sclk;
    bit ended;
    w = dw(d); dv = dd(d);
    busy_len = 0; cs_low = 0; rises = 0; dones = 0; errs = 0; first_rise = -1;
    done_at = -1; bad_cs = 0; mosi_w = 0; prev_sclk = 1'b0; ended = 0;
    @(negedge clk48);
    sel_dut = d; miso_loop = loop; miso_drv = mw[w-1];
    drive(d, 1'b1, sel, tx);
    @(negedge clk48);
    if (!hammer) drive(d, 1'b0, sel, tx);
    for (c = 0; c < 2000; c++) begin
      if (m_busy) busy_len++;
      if (m_cs_n != 3'b111) begin
        cs_low++;
        if (m_cs_n != exp_cs) bad_cs++;
      end
      if (m_sclk && m_cs_n == 3'b111) bad_cs++;
      if (m_sclk && !prev_sclk) begin
        if (first_rise < 0) first_rise = c;
        mosi_w = {mosi_w[30:0], m_mosi};
        rises++;
        if (!loop) miso_drv = (rises < w) ? mw[w-1-rises] : 1'b0;
      end
      if (m_done) begin dones++; if (done_at < 0) done_at = c; end
      if (m_err) errs++;
      prev_sclk = m_sclk;
      if (!m_busy) begin ended = 1; break; end
      @(negedge clk48);
    end
    chk({nm, "_ended"},      32'(ended),      32'd1);
    chk({nm, "_busy_len"},   32'(busy_len),   32'(exp_busy));
    chk({nm, "_cs_low_len"}, 32'(cs_low),     32'(exp_busy - G));
    chk({nm, "_cs_value"},   32'(bad_cs),     32'd0);
    chk({nm, "_sclk_rises"}, 32'(rises),      32'(w));
    chk({nm, "_first_rise"}, 32'(first_rise), 32'(S + dv));
    chk({nm, "_mosi_word"},  mosi_w & mask_w(d), tx & mask_w(d));
    chk({nm, "_done_cnt"},   32'(dones),      32'd1);
    chk({nm, "_done_at"},    32'(done_at),    32'(exp_busy - G));
    chk({nm, "_err_cnt"},    32'(errs),       32'd0);
    chk({nm, "_rx_word"},    m_rx,            exp_rx);
    if (hammer) begin
      // start still high on the cycle busy fell: a new transaction must begin now
      @(negedge clk48);
      chk({nm, "_restart"}, 32'(m_busy), 32'd1);
      drive(d, 1'b0, sel, tx);
      for (c = 0; c < 400 && m_busy; c++) @(negedge clk48);
      chk({nm, "_drain"}, 32'(m_busy), 32'd0);
    end
  endtask

  typedef struct {
    int          d;
    int          sel;
    logic [31:0] tx;
    bit          loop;
    logic [31:0] mw;
    bit          hammer;
    logic [2:0]  exp_cs;
    int          exp_busy;
    logic [31:0] exp_rx_on;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{d: 0, sel: 1, tx: 32'hA55A, loop: 1, mw: 32'h0,    hammer: 0, exp_cs: 3'b101, exp_busy: 133, exp_rx_on: 32'hA55A};
    vecs[1] = '{d: 0, sel: 0, tx: 32'h0000, loop: 0, mw: 32'hFFFF, hammer: 0, exp_cs: 3'b110, exp_busy: 133, exp_rx_on: 32'hFFFF};
    vecs[2] = '{d: 0, sel: 1, tx: 32'h1234, loop: 0, mw: 32'h5AC3, hammer: 1, exp_cs: 3'b101, exp_busy: 133, exp_rx_on: 32'h5AC3};
    vecs[3] = '{d: 1, sel: 2, tx: 32'h96,   loop: 1, mw: 32'h0,    hammer: 0, exp_cs: 3'b011, exp_busy: 21,  exp_rx_on: 32'h96};
    vecs[4] = '{d: 1, sel: 0, tx: 32'h3C,   loop: 0, mw: 32'hA5,   hammer: 0, exp_cs: 3'b110, exp_busy: 21,  exp_rx_on: 32'hA5};

    reset_n = 1'b0; sel_dut = 0; miso_loop = 1'b0; miso_drv = 1'b0;
    drive(0, 1'b0, 0, 32'h0);
    drive(1, 1'b0, 0, 32'h0);
    repeat (3) @(negedge clk48);
    check_idle(0, "reset_a", 1);
    check_idle(1, "reset_b", 1);
    reset_n = 1'b1;

    // table vectors
    for (int i = 0; i < 5; i++) begin
      logic [31:0] erx;
`ifdef SERIAL_RX_EN
      erx = vecs[i].exp_rx_on;
`else
      erx = 32'd0;
`endif
      run_txn($sformatf("vec%0d", i), vecs[i].d, vecs[i].sel, vecs[i].tx, vecs[i].loop,
              vecs[i].mw, vecs[i].hammer, vecs[i].exp_cs, vecs[i].exp_busy, erx);
    end

    // bad chip select on the 3-CS instance: err pulse only, no bus activity
    @(negedge clk48);
    sel_dut = 1;
    drive(1, 1'b1, 3, 32'h55);
    @(negedge clk48);
    drive(1, 1'b0, 3, 32'h55);
    chk("badsel_err",  32'(m_err),  32'd1);
    chk("badsel_busy", 32'(m_busy), 32'd0);
    chk("badsel_cs_n", 32'(m_cs_n), 32'h7);
    chk("badsel_sclk", 32'(m_sclk), 32'd0);
    @(negedge clk48);
    chk("badsel_err_pulse", 32'(m_err), 32'd0);
    check_idle(1, "badsel_after", 0);

    // reset in the middle of a transaction
    @(negedge clk48);
    sel_dut = 0; miso_loop = 1'b1;
    drive(0, 1'b1, 1, 32'hFFFF);
    @(negedge clk48);
    drive(0, 1'b0, 1, 32'hFFFF);
    repeat (39) @(negedge clk48);
    chk("midrst_active", 32'(m_busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk48);
    check_idle(0, "midrst", 1);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk48);
      chk("midrst_no_done", 32'(m_done | m_busy), 32'd0);
    end
    run_txn("postrst", 0, 0, 32'hC0DE, 1'b1, 32'h0, 1'b0, 3'b110, model_busy(0),
            model_rx(0, 1'b1, 32'hC0DE, 32'h0));

    // random transactions against the reference model
    for (int i = 0; i < 12; i++) begin
      int d, sel;
      logic [31:0] tx, mw;
      bit loop;
      d    = $urandom_range(0, 1);
      sel  = (d == 0) ? $urandom_range(0, 1) : $urandom_range(0, 2);
      tx   = $urandom;
      mw   = $urandom;
      loop = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", i), d, sel, tx, loop, mw, 1'b0,
              3'b111 & ~(3'b001 << sel), model_busy(d), model_rx(d, loop, tx, mw));
    end

    repeat (3) @(negedge clk48);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
